// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and default width for the multiply/divide unit
package muldiv_pkg;
  localparam int MULDIV_W = 32;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add (mul) or restoring-subtract (div) iteration
module muldiv_step import muldiv_pkg::*; #(
  parameter int WIDTH = MULDIV_W
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             div_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rs;
  logic           ge;
  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    rs   = {hi_i, lo_i[WIDTH-1]};
    ge   = rs >= {1'b0, opnd_i};
    hi_o = div_i ? (ge ? WIDTH'(rs - {1'b0, opnd_i}) : rs[WIDTH-1:0]) : sum[WIDTH:1];
    lo_o = div_i ? {lo_i[WIDTH-2:0], ge} : {sum[0], lo_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide with architectural HI/LO
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = MULDIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  muldiv_state_t      state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, opnd_q, hi_q, lo_q;
  logic [WIDTH-1:0]   step_hi, step_lo, abs_a, abs_b, hi_d, lo_d;
  logic [2*WIDTH-1:0] prod_d;
  logic               neg_q, neg_rem_q, busy_q, done_q;
  logic               signed_op, is_mul, is_div, accept;
  assign signed_op = op == OP_MULT || op == OP_DIV;
  assign is_mul    = op == OP_MULT || op == OP_MULTU;
  assign is_div    = op == OP_DIV || op == OP_DIVU;
  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign abs_a     = signed_op && a[WIDTH-1] ? -a : a;
  assign abs_b     = signed_op && b[WIDTH-1] ? -b : b;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .hi_i  (acc_hi_q),
    .lo_i  (acc_lo_q),
    .opnd_i(opnd_q),
    .div_i (state_q == DIV),
    .hi_o  (step_hi),
    .lo_o  (step_lo)
  );
  // The remainder follows the dividend's sign; quotient/product follow the sign xor.
  assign prod_d = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
  assign hi_d   = state_q == DIV ? (neg_rem_q ? -step_hi : step_hi) : prod_d[2*WIDTH-1:WIDTH];
  assign lo_d   = state_q == DIV ? (neg_q ? -step_lo : step_lo) : prod_d[WIDTH-1:0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= IDLE;
        if (op == OP_MTHI) hi_q <= a;
        if (op == OP_MTLO) lo_q <= a;
        if (is_mul || is_div) begin
          state_q   <= is_div ? DIV : MUL;
          busy_q    <= 1'b1;
          cnt_q     <= CW'(WIDTH - 1);
          acc_hi_q  <= '0;
          acc_lo_q  <= is_div ? abs_a : abs_b;
          opnd_q    <= is_div ? abs_b : abs_a;
          // A zero divisor keeps the all-ones quotient unnegated.
          neg_q     <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]) && (is_mul || |b);
          neg_rem_q <= signed_op && a[WIDTH-1];
        end
      end else if (busy_q) begin
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
        cnt_q    <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          cnt_q   <= '0;
        end
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the ALU in EX and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It holds `busy` so the hazard logic stalls any later HI/LO consumer or new mul/div until the result is committed. One shared shift-add/restoring-subtract datapath serves all four arithmetic ops.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be a power of two ≥ 8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request from EX; ignored while `busy`=1.
- `op`  in  3  `muldiv_op_t`: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO; other codes are no-ops.
- `a`  in  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO source).
- `b`  in  WIDTH  rt value (multiplier/divisor).
- `busy`  out  1  registered; high while an iteration is in flight.
- `done`  out  1  one-cycle pulse on the cycle HI/LO first shows a mul/div result.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers (MFHI/MFLO read these directly).

## Operation
- States: IDLE, MUL, DIV, DONE (`muldiv_state_t`).
- Accept condition: `start`=1 in IDLE or DONE. Inputs are sampled only on the accepting edge; later changes to `a`/`b`/`op` are ignored.
- MTHI/MTLO: on the accepting edge, `hi`/`lo` ← `a`. State stays or returns to IDLE; `busy` stays 0; no `done`.
- MULT/MULTU/DIV/DIVU: on the accepting edge, latch operand magnitudes (signed ops: two's-complement absolute value; unsigned: raw) and the result-sign flags. Load counter = WIDTH-1, enter MUL or DIV.
- MUL iteration: if multiplier LSB is set, add multiplicand into the upper half of a 2·WIDTH accumulator (WIDTH+1-bit add keeps the carry), then shift right 1.
- DIV iteration: restoring step. Shift {rem,quot} left 1, trial-subtract divisor from rem; if no borrow, keep the difference and set quot LSB.
- Iteration with counter=0: write `hi`/`lo` with sign fixup, enter DONE.
  - Product is negated as a 2·WIDTH value if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
- DONE: `done`=1, `busy`=0 for exactly one cycle, then IDLE unless a new op is accepted in that cycle.
- Divide by zero: normal latency; `lo` = all ones, `hi` = `a` (dividend as given).
- Signed −2^(WIDTH−1) ÷ −1: `lo` = 0x80000000, `hi` = 0 (falls out of the magnitude algorithm; no special case).
- `hi`/`lo` are never partially updated mid-iteration. MFHI/MFLO during `busy` must be stalled externally.
- Reset (asserted at any time, including mid-iteration): state IDLE, `hi`=`lo`=0, `busy`=0, `done`=0, counter 0. The in-flight op is discarded.

## Timing
- Accepting edge E0. `busy`=1 during cycles E0+1 … E0+WIDTH (WIDTH cycles).
- Results are visible and `done`=1 in cycle E0+WIDTH+1.
- Mul/div latency: WIDTH+1 cycles from the accepting edge. MTHI/MTLO latency: 1 cycle.
- `busy` and `done` are never both 1. Back-to-back: a start accepted in DONE gives `busy`=1 in the next cycle with no idle gap.

## Structure
- `muldiv_pkg`: `muldiv_op_t` enum (3 bits), `muldiv_state_t` enum, and `MULDIV_W` = 32 as the default for `WIDTH`.
- Main decoder encodes `op` from opcode/funct alongside the ALU control decoder.
- One sub-module, `muldiv_step`: combinational single-iteration datapath. Inputs: accumulator pair, operand, and a mul/div select. Outputs: next accumulator pair.
- FSM, counter, sign handling and HI/LO registers live in `muldiv_unit`.

## Test plan
- Reset mid-iteration: DIVU 100/7, reset asserted at E0+5 → `busy`, `done`, `hi`, `lo` all 0 immediately (asynchronous); a later op runs normally.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` pulses exactly at E0+33; `busy` is high for exactly 32 cycles.
- MULT −7×6 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFD6. DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 5/0 → `lo`=0xFFFFFFFF, `hi`=5 at normal latency. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- `start` with DIVU 9/2 held high while `busy` → ignored. Start accepted in the DONE cycle → second result after another 33 cycles with no extra idle cycle.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → `hi`=0x1234, `lo`=0x5678 one cycle each; `busy`/`done` stay 0.
